// File: rtl/reduce_nway_pipe_pkg.sv
// Mode encodings and bit-level helpers shared by the N-way reduction pipeline.
package reduce_nway_pipe_pkg;

   localparam logic [1:0] MODE_OR  = 2'b00;
   localparam logic [1:0] MODE_AND = 2'b01;
   localparam logic [1:0] MODE_XOR = 2'b10;
   localparam logic [1:0] MODE_NOR = 2'b11;

   function automatic logic mode_identity(input logic [1:0] mode);
      logic id;
      case (mode)
         MODE_AND: id = 1'b1;
         default:  id = 1'b0;
      endcase
      return id;
   endfunction

   // NOR folds as OR; the inversion happens once, when the packet closes
   function automatic logic combine(input logic [1:0] mode, input logic a, input logic b);
      logic r;
      case (mode)
         MODE_AND: r = a & b;
         MODE_XOR: r = a ^ b;
         default:  r = a | b;
      endcase
      return r;
   endfunction

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((32'sd1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/reduce_nway_pipe_level.sv
// One registered tree level: folds adjacent bit pairs with the beat's mode.
module reduce_level
   import reduce_nway_pipe_pkg::*;
#(
   parameter int IN_W = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic [1:0]        mode_in,
   input  logic              valid_in,
   input  logic              last_in,
   input  logic [IN_W-1:0]   data_in,
   output logic [1:0]        mode_out,
   output logic              valid_out,
   output logic              last_out,
   output logic [IN_W/2-1:0] data_out
);
   localparam int OUT_W = IN_W / 2;

   logic [OUT_W-1:0] data_d, data_q;
   logic [1:0]       mode_d, mode_q;
   logic             valid_d, valid_q;
   logic             last_d, last_q;

   // Pairwise fold when the pipeline advances, hold otherwise
   always_comb begin
      data_d  = data_q;
      mode_d  = mode_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (en) begin
         for (int i = 0; i < OUT_W; i++) begin
            data_d[i] = combine(mode_in, data_in[2*i], data_in[2*i+1]);
         end
         mode_d  = mode_in;
         valid_d = valid_in;
         last_d  = last_in;
      end else begin
         valid_d = valid_q;
      end
   end

   // Level registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q  <= '0;
         mode_q  <= 2'b00;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         mode_q  <= mode_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign data_out  = data_q;
   assign mode_out  = mode_q;
   assign valid_out = valid_q;
   assign last_out  = last_q;

endmodule

// File: rtl/reduce_nway_pipe.sv
// Pipelined N-input bitwise reduction: input register, LEVELS-deep balanced tree,
// then a packet accumulator delivering one result bit per packet.
module reduce_nway_pipe
   import reduce_nway_pipe_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int LEVELS = clog2(WIDTH);
   localparam int PAD_W  = 1 << LEVELS;

   logic             advance;
   logic [WIDTH-1:0] beat_d, beat_q;
   logic [1:0]       beat_mode_d, beat_mode_q;
   logic             beat_valid_d, beat_valid_q;
   logic             beat_last_d, beat_last_q;
   logic             in_pkt_d, in_pkt_q;
   logic [1:0]       in_pkt_mode_d, in_pkt_mode_q;
   logic [PAD_W-1:0] leaves;
   logic             tree_data, tree_valid, tree_last;
   logic [1:0]       tree_mode;
   logic             acc_d, acc_q;
   logic [1:0]       pkt_mode_d, pkt_mode_q;
   logic             pkt_open_d, pkt_open_q;
   logic             out_d, out_q, out_valid_d, out_valid_q;
   logic [1:0]       close_mode;
   logic             beat_res;

   assign advance   = !out_valid_q || out_ready;
   assign in_ready  = advance;
   assign out       = out_q;
   assign out_valid = out_valid_q;

   // Input capture; non-first beats inherit the mode of their packet's first beat
   always_comb begin
      beat_d        = beat_q;
      beat_mode_d   = beat_mode_q;
      beat_valid_d  = beat_valid_q;
      beat_last_d   = beat_last_q;
      in_pkt_d      = in_pkt_q;
      in_pkt_mode_d = in_pkt_mode_q;
      if (advance) begin
         beat_d       = in;
         beat_valid_d = in_valid;
         beat_last_d  = in_last;
         beat_mode_d  = in_pkt_q ? in_pkt_mode_q : mode;
         if (in_valid) begin
            in_pkt_d      = !in_last;
            in_pkt_mode_d = beat_mode_d;
         end else begin
            in_pkt_d      = in_pkt_q;
         end
      end else begin
         beat_valid_d = beat_valid_q;
      end
   end

   always_comb begin
      leaves            = {PAD_W{mode_identity(beat_mode_q)}};
      leaves[WIDTH-1:0] = beat_q;
   end

   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int IN_W = PAD_W >> l;
      logic [IN_W-1:0]   d_in;
      logic [IN_W/2-1:0] d_out;
      logic [1:0]        m_in, m_out;
      logic              v_in, v_out, lst_in, lst_out;
      if (l == 0) begin : g_src
         assign d_in   = leaves;
         assign m_in   = beat_mode_q;
         assign v_in   = beat_valid_q;
         assign lst_in = beat_last_q;
      end else begin : g_src
         assign d_in   = g_lvl[l-1].d_out;
         assign m_in   = g_lvl[l-1].m_out;
         assign v_in   = g_lvl[l-1].v_out;
         assign lst_in = g_lvl[l-1].lst_out;
      end
      reduce_level #(.IN_W(IN_W)) u_level (
         .clk       (clk),
         .reset_n   (reset_n),
         .en        (advance),
         .mode_in   (m_in),
         .valid_in  (v_in),
         .last_in   (lst_in),
         .data_in   (d_in),
         .mode_out  (m_out),
         .valid_out (v_out),
         .last_out  (lst_out),
         .data_out  (d_out)
      );
   end

   assign tree_data  = g_lvl[LEVELS-1].d_out[0];
   assign tree_mode  = g_lvl[LEVELS-1].m_out;
   assign tree_valid = g_lvl[LEVELS-1].v_out;
   assign tree_last  = g_lvl[LEVELS-1].lst_out;

   // Packet fold: the first beat seeds the accumulator, the last beat loads the output
   always_comb begin
      acc_d       = acc_q;
      pkt_mode_d  = pkt_mode_q;
      pkt_open_d  = pkt_open_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      close_mode  = pkt_open_q ? pkt_mode_q : tree_mode;
      beat_res    = pkt_open_q ? combine(pkt_mode_q, acc_q, tree_data) : tree_data;
      if (advance) begin
         out_valid_d = 1'b0;
         if (tree_valid && tree_last) begin
            out_d       = (close_mode == MODE_NOR) ? ~beat_res : beat_res;
            out_valid_d = 1'b1;
            pkt_open_d  = 1'b0;
         end else if (tree_valid) begin
            acc_d      = beat_res;
            pkt_mode_d = close_mode;
            pkt_open_d = 1'b1;
         end else begin
            pkt_open_d = pkt_open_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Input and accumulator-stage registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         beat_q        <= '0;
         beat_mode_q   <= 2'b00;
         beat_valid_q  <= 1'b0;
         beat_last_q   <= 1'b0;
         in_pkt_q      <= 1'b0;
         in_pkt_mode_q <= 2'b00;
         acc_q         <= 1'b0;
         pkt_mode_q    <= 2'b00;
         pkt_open_q    <= 1'b0;
         out_q         <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         beat_q        <= beat_d;
         beat_mode_q   <= beat_mode_d;
         beat_valid_q  <= beat_valid_d;
         beat_last_q   <= beat_last_d;
         in_pkt_q      <= in_pkt_d;
         in_pkt_mode_q <= in_pkt_mode_d;
         acc_q         <= acc_d;
         pkt_mode_q    <= pkt_mode_d;
         pkt_open_q    <= pkt_open_d;
         out_q         <= out_d;
         out_valid_q   <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_reduce_nway_pipe.sv
// Directed bench for reduce_nway_pipe: an 8-bit build for the main behaviour
// and a 5-bit build for identity padding.
module tb_reduce_nway_pipe;

   localparam logic [1:0] M_OR  = 2'b00;
   localparam logic [1:0] M_AND = 2'b01;
   localparam logic [1:0] M_XOR = 2'b10;
   localparam logic [1:0] M_NOR = 2'b11;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] in_8;
   logic [1:0] mode_8;
   logic       in_valid_8, in_last_8, in_ready_8, out_8, out_valid_8, out_ready_8;
   logic [4:0] in_5;
   logic [1:0] mode_5;
   logic       in_valid_5, in_last_5, in_ready_5, out_5, out_valid_5, out_ready_5;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   reduce_nway_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .in(in_8), .mode(mode_8),
      .in_valid(in_valid_8), .in_last(in_last_8), .in_ready(in_ready_8),
      .out(out_8), .out_valid(out_valid_8), .out_ready(out_ready_8)
   );

   reduce_nway_pipe #(.WIDTH(5)) dut5 (
      .clk(clk), .reset_n(reset_n), .in(in_5), .mode(mode_5),
      .in_valid(in_valid_5), .in_last(in_last_5), .in_ready(in_ready_5),
      .out(out_5), .out_valid(out_valid_5), .out_ready(out_ready_5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send8(input logic [7:0] d, input logic [1:0] m, input logic last);
      int n;
      n = 0;
      while (!in_ready_8 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready_8) check("send_ready", 32'(in_ready_8), 32'd1);
      in_8 = d; mode_8 = m; in_last_8 = last; in_valid_8 = 1'b1;
      @(posedge clk); #1;
      in_valid_8 = 1'b0;
   endtask

   // Single-beat packet: result must appear exactly 4 edges after acceptance
   task automatic run8(input logic [7:0] d, input logic [1:0] m, input logic exp, input string tag);
      send8(d, m, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check({tag, "_early"}, 32'(out_valid_8), 32'd0);
      end
      @(posedge clk); #1;
      check({tag, "_valid"}, 32'(out_valid_8), 32'd1);
      check({tag, "_out"}, 32'(out_8), 32'(exp));
      @(posedge clk); #1;
      check({tag, "_clear"}, 32'(out_valid_8), 32'd0);
   endtask

   task automatic run5(input logic [4:0] d, input logic [1:0] m, input logic exp, input string tag);
      check({tag, "_rdy"}, 32'(in_ready_5), 32'd1);
      in_5 = d; mode_5 = m; in_last_5 = 1'b1; in_valid_5 = 1'b1;
      @(posedge clk); #1;
      in_valid_5 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check({tag, "_early"}, 32'(out_valid_5), 32'd0);
      end
      @(posedge clk); #1;
      check({tag, "_valid"}, 32'(out_valid_5), 32'd1);
      check({tag, "_out"}, 32'(out_5), 32'(exp));
      @(posedge clk); #1;
   endtask

   // Counts result pulses over a fixed window after the last beat of a packet
   task automatic watch8(input logic exp, input string tag);
      int   pulses;
      logic val;
      pulses = 0;
      val    = 1'bx;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid_8) begin
            pulses++;
            val = out_8;
         end
      end
      check({tag, "_pulses"}, 32'(pulses), 32'd1);
      check({tag, "_out"}, 32'(val), 32'(exp));
   endtask

   initial begin
      logic [7:0] sd [4];
      logic [1:0] sm [4];
      logic       se [4];
      logic       got [4];
      int         n;

      reset_n = 1'b0;
      in_8 = 8'h00; mode_8 = M_OR; in_valid_8 = 1'b0; in_last_8 = 1'b0; out_ready_8 = 1'b1;
      in_5 = 5'h00; mode_5 = M_OR; in_valid_5 = 1'b0; in_last_5 = 1'b0; out_ready_5 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid_8), 32'd0);
      check("rst_out", 32'(out_8), 32'd0);
      check("rst_in_ready", 32'(in_ready_8), 32'd1);
      check("rst_out_valid_w5", 32'(out_valid_5), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run8(8'h00, M_OR,  1'b0, "or_00");
      run8(8'h10, M_OR,  1'b1, "or_10");
      run8(8'hFF, M_AND, 1'b1, "and_ff");
      run8(8'hFE, M_AND, 1'b0, "and_fe");
      run8(8'h07, M_XOR, 1'b1, "xor_07");
      run8(8'h03, M_XOR, 1'b0, "xor_03");
      run8(8'h00, M_NOR, 1'b1, "nor_00");
      run8(8'h01, M_NOR, 1'b0, "nor_01");

      run5(5'h1F, M_AND, 1'b1, "w5_and_1f");
      run5(5'h0F, M_AND, 1'b0, "w5_and_0f");
      run5(5'h10, M_OR,  1'b1, "w5_or_10");

      send8(8'h00, M_OR, 1'b0);
      send8(8'h00, M_OR, 1'b0);
      send8(8'h04, M_OR, 1'b1);
      watch8(1'b1, "or3");

      // Beat 2 asks for OR; the packet must still fold as AND
      send8(8'h00, M_AND, 1'b0);
      send8(8'hFF, M_OR,  1'b0);
      send8(8'hFF, M_AND, 1'b1);
      watch8(1'b0, "and3_mixed");

      sd[0] = 8'h10; sm[0] = M_OR;  se[0] = 1'b1;
      sd[1] = 8'h00; sm[1] = M_OR;  se[1] = 1'b0;
      sd[2] = 8'h07; sm[2] = M_XOR; se[2] = 1'b1;
      sd[3] = 8'hFE; sm[3] = M_AND; se[3] = 1'b0;
      out_ready_8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("stall_pre_ready", 32'(in_ready_8), 32'd1);
         in_8 = sd[i]; mode_8 = sm[i]; in_last_8 = 1'b1; in_valid_8 = 1'b1;
         @(posedge clk); #1;
      end
      in_valid_8 = 1'b0;
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid_8), 32'd1);
      check("stall_ready_drop", 32'(in_ready_8), 32'd0);
      check("stall_first_out", 32'(out_8), 32'(se[0]));
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("stall_hold_valid", 32'(out_valid_8), 32'd1);
         check("stall_hold_out", 32'(out_8), 32'(se[0]));
         check("stall_hold_ready", 32'(in_ready_8), 32'd0);
      end
      out_ready_8 = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && n < 4; c++) begin
         if (out_valid_8) begin
            got[n] = out_8;
            n++;
         end
         @(posedge clk); #1;
      end
      check("stall_count", 32'(n), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < n) check("stall_order", 32'(got[i]), 32'(se[i]));
      end

      send8(8'hFF, M_AND, 1'b0);
      send8(8'h00, M_AND, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      check("partial_no_valid", 32'(out_valid_8), 32'd0);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_out_valid", 32'(out_valid_8), 32'd0);
      check("midrst_in_ready", 32'(in_ready_8), 32'd1);
      reset_n = 1'b1;
      run8(8'hFF, M_OR, 1'b1, "post_rst_or_ff");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
